// File: rtl/ntr_pkg.sv
// Shared constants for the NTR cartridge bus front end.
package ntr_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned CMD_BYTES = 8;
    localparam int unsigned CMD_W     = DATA_W * CMD_BYTES;
    localparam int unsigned CNT_W     = $clog2(CMD_BYTES + 1);

    // Idle (deasserted) level of the raw bus control pins.
    localparam logic IDLE = 1'b1;

endpackage : ntr_pkg

// File: rtl/ntr_debounce.sv
// Two-flop synchronizer followed by a stability counter; the output only
// follows the input after DB_STAGES consecutive equal synchronized samples.
module ntr_debounce
    import ntr_pkg::*;
#(
    parameter int unsigned DB_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int unsigned CW = (DB_STAGES > 1) ? $clog2(DB_STAGES) : 1;

    logic [1:0]    sync_q;
    logic          out_q;
    logic          out_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Metastability guard for the asynchronous pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {IDLE, IDLE};
        end else begin
            sync_q <= {sync_q[0], din};
        end
    end

    // Count consecutive samples that disagree with the output; commit on the last one.
    always_comb begin
        out_d = out_q;
        cnt_d = '0;
        if (sync_q[1] != out_q) begin
            if (cnt_q == CW'(DB_STAGES - 1)) begin
                out_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Debounced level and stability counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= IDLE;
            cnt_q <= '0;
        end else begin
            out_q <= out_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout = out_q;

endmodule : ntr_debounce

// File: rtl/ntr_cmd_frontend.sv
// NTR cartridge bus front end: pin debounce, data pad, and command byte capture.
module ntr_cmd_frontend
    import ntr_pkg::*;
#(
    parameter int unsigned DB_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ntr_clk,
    input  logic              ntr_cs1,
    inout  wire  [DATA_W-1:0] ntr_data,
    input  logic              bus_dir,
    input  logic [DATA_W-1:0] bus_data_out,
    output logic [DATA_W-1:0] bus_data_in,
    output logic [CMD_W-1:0]  command,
    output logic              ready,
    output logic              cmd_strobe,
    output logic [CNT_W-1:0]  count
);

    logic clk_db;
    logic cs1_db;

    ntr_debounce #(.DB_STAGES(DB_STAGES)) u_db_clk (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ntr_clk),
        .dout  (clk_db)
    );

    ntr_debounce #(.DB_STAGES(DB_STAGES)) u_db_cs1 (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ntr_cs1),
        .dout  (cs1_db)
    );

    // Bidirectional pad; the raw pad value is always visible.
    assign ntr_data    = bus_dir ? bus_data_out : {DATA_W{1'bz}};
    assign bus_data_in = ntr_data;

    logic             clk_prev_q;
    logic             cs1_prev_q;
    logic             strobe_c;
    logic             cs_act_c;
    logic             cs_rise_c;
    logic [CMD_W-1:0] command_q, command_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic             ready_q,   ready_d;
    logic             cmd_strobe_q, cmd_strobe_d;
    logic [CNT_W-1:0] base_count_c;
    logic             base_ready_c;

    assign strobe_c  = clk_db & ~clk_prev_q;
    assign cs_act_c  = ~cs1_db;
    assign cs_rise_c = cs_act_c & cs1_prev_q;

    // Frame tracking and byte shift; a new frame clears the count before any same-cycle byte.
    always_comb begin
        command_d    = command_q;
        count_d      = '0;
        ready_d      = 1'b0;
        cmd_strobe_d = 1'b0;
        base_count_c = cs_rise_c ? '0 : count_q;
        base_ready_c = cs_rise_c ? 1'b0 : ready_q;
        if (cs_act_c) begin
            count_d = base_count_c;
            ready_d = base_ready_c;
            if (strobe_c && (base_count_c < CNT_W'(CMD_BYTES))) begin
                command_d = {command_q[CMD_W-DATA_W-1:0], bus_data_in};
                count_d   = base_count_c + CNT_W'(1);
                if (base_count_c == CNT_W'(CMD_BYTES - 1)) begin
                    ready_d      = 1'b1;
                    cmd_strobe_d = 1'b1;
                end
            end
        end
    end

    // Edge history and command state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_prev_q   <= IDLE;
            cs1_prev_q   <= IDLE;
            command_q    <= '0;
            count_q      <= '0;
            ready_q      <= 1'b0;
            cmd_strobe_q <= 1'b0;
        end else begin
            clk_prev_q   <= clk_db;
            cs1_prev_q   <= cs1_db;
            command_q    <= command_d;
            count_q      <= count_d;
            ready_q      <= ready_d;
            cmd_strobe_q <= cmd_strobe_d;
        end
    end

    assign command    = command_q;
    assign count      = count_q;
    assign ready      = ready_q;
    assign cmd_strobe = cmd_strobe_q;

endmodule : ntr_cmd_frontend

// File: tb/tb_ntr_cmd_frontend.sv
// Directed bench for the NTR command front end.
module tb_ntr_cmd_frontend;
    import ntr_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ntr_clk;
    logic              ntr_cs1;
    wire  [DATA_W-1:0] ntr_data;
    logic              bus_dir;
    logic [DATA_W-1:0] bus_data_out;
    logic [DATA_W-1:0] bus_data_in;
    logic [CMD_W-1:0]  command;
    logic              ready;
    logic              cmd_strobe;
    logic [CNT_W-1:0]  count;

    logic              tb_drv_en;
    logic [DATA_W-1:0] tb_drv_val;

    int total = 0;
    int bad   = 0;
    int strobe_seen = 0;

    assign ntr_data = tb_drv_en ? tb_drv_val : {DATA_W{1'bz}};

    always #5 clk = ~clk;

    ntr_cmd_frontend #(.DB_STAGES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ntr_clk      (ntr_clk),
        .ntr_cs1      (ntr_cs1),
        .ntr_data     (ntr_data),
        .bus_dir      (bus_dir),
        .bus_data_out (bus_data_out),
        .bus_data_in  (bus_data_in),
        .command      (command),
        .ready        (ready),
        .cmd_strobe   (cmd_strobe),
        .count        (count)
    );

    // Count high cycles of the command strobe.
    always @(posedge clk) begin
        if (cmd_strobe) strobe_seen <= strobe_seen + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bus byte: data set while ntr_clk is low, held across the rising edge.
    task automatic send_byte(input logic [7:0] b);
        tb_drv_val = b;
        ntr_clk    = 1'b0;
        tick(6);
        ntr_clk    = 1'b1;
        tick(6);
    endtask

    initial begin
        rst_n        = 1'b0;
        ntr_clk      = 1'b1;
        ntr_cs1      = 1'b1;
        bus_dir      = 1'b0;
        bus_data_out = 8'h00;
        tb_drv_en    = 1'b1;
        tb_drv_val   = 8'h00;
        tick(3);
        chk("rst_count",  64'(count), 64'd0);
        chk("rst_ready",  64'(ready), 64'd0);
        chk("rst_cmd",    command, 64'd0);
        chk("rst_strobe", 64'(cmd_strobe), 64'd0);
        rst_n = 1'b1;
        tick(3);

        // Full 8-byte frame.
        ntr_cs1 = 1'b0;
        tick(6);
        chk("frame_start_count", 64'(count), 64'd0);
        for (int i = 1; i <= 8; i++) begin
            send_byte(8'(i));
            chk($sformatf("count_b%0d", i), 64'(count), 64'(i));
        end
        chk("cmd_full",    command, 64'h0102030405060708);
        chk("ready_full",  64'(ready), 64'd1);
        chk("strobe_once", 64'(strobe_seen), 64'd1);

        // Saturation: extra byte ignored.
        send_byte(8'hAA);
        chk("sat_count",  64'(count), 64'd8);
        chk("sat_cmd",    command, 64'h0102030405060708);
        chk("sat_ready",  64'(ready), 64'd1);
        chk("sat_strobe", 64'(strobe_seen), 64'd1);

        // CS1 deassert clears frame, command held.
        ntr_cs1 = 1'b1;
        tick(6);
        chk("cs_hi_count", 64'(count), 64'd0);
        chk("cs_hi_ready", 64'(ready), 64'd0);
        chk("cs_hi_cmd",   command, 64'h0102030405060708);

        // New frame, one byte, then a 1-clk rising glitch on ntr_clk.
        ntr_cs1 = 1'b0;
        tick(6);
        send_byte(8'h11);
        chk("f2_count1", 64'(count), 64'd1);
        tb_drv_val = 8'h22;
        ntr_clk    = 1'b0;
        tick(6);
        ntr_clk = 1'b1;
        tick(1);
        ntr_clk = 1'b0;
        tick(8);
        chk("glitch_count", 64'(count), 64'd1);
        ntr_clk = 1'b1;
        tick(6);
        chk("f2_count2", 64'(count), 64'd2);
        chk("f2_cmd",    command, 64'h0304050607081122);

        // Pad direction.
        tb_drv_en    = 1'b0;
        bus_dir      = 1'b1;
        bus_data_out = 8'h5A;
        #1;
        chk("pad_out", 64'(ntr_data), 64'h5A);
        chk("pad_in_loop", 64'(bus_data_in), 64'h5A);
        bus_dir    = 1'b0;
        tb_drv_en  = 1'b1;
        tb_drv_val = 8'hC3;
        #1;
        chk("pad_in_ext", 64'(bus_data_in), 64'hC3);
        tick(1);

        // Async reset mid-frame.
        send_byte(8'h33);
        send_byte(8'h44);
        chk("pre_rst_count", 64'(count), 64'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_ready", 64'(ready), 64'd0);
        chk("arst_cmd",   command, 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ntr_cmd_frontend
